// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a
// single-entry valid/ready output buffer with sticky overrun and frame error pulse.
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clr_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HI
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          r_meta;
    logic          r_rx_s;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_ferr;
    logic          r_ovr;

    state_t        w_state_nx;
    logic [CW-1:0] w_cnt_nx;
    logic [2:0]    w_idx_nx;
    logic [7:0]    w_shift_nx;
    logic          w_deliver;
    logic          w_ferr;
    logic          w_accept;
    logic          w_ovr_evt;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_shift_nx = r_shift;
        w_deliver  = 1'b0;
        w_ferr     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                w_idx_nx = '0;
                if (!r_rx_s) begin
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                // Re-check the line half a bit in to reject short glitches
                if (r_cnt == HALF) begin
                    w_cnt_nx   = '0;
                    w_idx_nx   = '0;
                    w_state_nx = r_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (r_cnt == LAST) begin
                    w_cnt_nx   = '0;
                    w_shift_nx = {r_rx_s, r_shift[7:1]};
                    if (r_idx == 3'd7) begin
                        w_state_nx = S_STOP;
                    end else begin
                        w_idx_nx = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (r_cnt == LAST) begin
                    w_cnt_nx = '0;
                    if (r_rx_s) begin
                        w_deliver  = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_ferr     = 1'b1;
                        w_state_nx = S_WAIT_HI;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            S_WAIT_HI: begin
                if (r_rx_s) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
        if (!ena) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
            w_idx_nx   = '0;
            w_deliver  = 1'b0;
            w_ferr     = 1'b0;
        end
    end

    // A held byte may be replaced only if the consumer takes it this cycle
    assign w_accept  = w_deliver && (!r_valid || data_ready);
    assign w_ovr_evt = w_deliver && r_valid && !data_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= 8'h00;
            r_meta  <= 1'b1;
            r_rx_s  <= 1'b1;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_meta  <= rx;
            r_rx_s  <= r_meta;
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_shift <= w_shift_nx;
            r_ferr  <= w_ferr;
            if (w_accept) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && data_ready) begin
                r_valid <= 1'b0;
            end
            if (w_ovr_evt) begin
                r_ovr <= 1'b1;
            end else if (clr_err) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;
    assign busy       = (r_state != S_IDLE);

endmodule
